priority_dec_pulse_v: RTL and testbench

//  Return path for the priority encoders: takes a binary line code plus valid,

---
 rtl/priority_dec_pulse_v.sv | 162 ++++++++++++++++
 tb/tb_priority_dec_pulse_v.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/priority_dec_pulse_v.sv
`default_nettype none
// ---------------------------------------------------------------------------
// priority_dec_pulse_v: decodes a binary line code to a one-hot select and
// drives it for HOLD_CYCLES, with a one-entry pending slot.  Rev 1.0
// ---------------------------------------------------------------------------
module priority_dec_pulse_v #(
  parameter int CODE_W      = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [CODE_W-1:0]        i_code,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_abort,
  output logic [(2**CODE_W)-1:0]   o_onehot,
  output logic                     o_active,
  output logic [CODE_W-1:0]        o_code_q,
  output logic                     o_done
);

  localparam int ONEHOT_W = 2**CODE_W;
  localparam int MAX_CNT  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W    = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ONEHOT_W-1:0]   onehot_q, onehot_d;
  logic [CODE_W-1:0]     code_q, code_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [CODE_W-1:0]     pend_code_q, pend_code_d;

  logic                  w_xfer;
  logic                  w_nxt_v;
  logic [CODE_W-1:0]     w_nxt_code;

  function automatic logic [ONEHOT_W-1:0] decode(input logic [CODE_W-1:0] c);
    logic [ONEHOT_W-1:0] r;
    r    = '0;
    r[c] = 1'b1;
    return r;
  endfunction

  assign o_ready  = i_rst_n & ~pend_valid_q & ~i_abort;
  assign w_xfer   = i_valid & o_ready;
  // A code accepted on the consuming edge is forwarded as if it were pending,
  // so IDLE is never entered with an entry outstanding.
  assign w_nxt_v    = pend_valid_q | w_xfer;
  assign w_nxt_code = pend_valid_q ? pend_code_q : i_code;

  assign o_onehot = onehot_q;
  assign o_active = (state_q == ST_HOLD);
  assign o_code_q = code_q;
  assign o_done   = (state_q == ST_HOLD) & (cnt_q == '0) & ~i_abort;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    onehot_d     = onehot_q;
    code_d       = code_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;

    if (i_abort) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      onehot_d     = '0;
      pend_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_xfer) begin
            state_d  = ST_HOLD;
            cnt_d    = HOLD_LOAD;
            onehot_d = decode(i_code);
            code_d   = i_code;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            if (GAP_CYCLES > 0) begin
              state_d      = ST_GAP;
              cnt_d        = GAP_LOAD;
              onehot_d     = '0;
              pend_valid_d = w_nxt_v;
              pend_code_d  = w_nxt_code;
            end else if (w_nxt_v) begin
              state_d      = ST_HOLD;
              cnt_d        = HOLD_LOAD;
              onehot_d     = decode(w_nxt_code);
              code_d       = w_nxt_code;
              pend_valid_d = 1'b0;
            end else begin
              state_d  = ST_IDLE;
              onehot_d = '0;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (w_xfer) begin
              pend_valid_d = 1'b1;
              pend_code_d  = i_code;
            end
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            if (w_nxt_v) begin
              state_d      = ST_HOLD;
              cnt_d        = HOLD_LOAD;
              onehot_d     = decode(w_nxt_code);
              code_d       = w_nxt_code;
              pend_valid_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (w_xfer) begin
              pend_valid_d = 1'b1;
              pend_code_d  = i_code;
            end
          end
        end
        default: begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          onehot_d     = '0;
          pend_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      onehot_q     <= '0;
      code_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      onehot_q     <= onehot_d;
      code_q       <= code_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_priority_dec_pulse_v.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_priority_dec_pulse_v: directed vector bench; instance A uses GAP=1,
// instance B uses GAP=0.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_priority_dec_pulse_v;

  logic       clk;
  logic       rst_n;

  logic [1:0] a_code, b_code;
  logic       a_valid, b_valid, a_abort, b_abort;
  logic       a_ready, b_ready, a_active, b_active, a_done, b_done;
  logic [3:0] a_onehot, b_onehot;
  logic [1:0] a_codeq, b_codeq;

  int checks = 0;
  int errors = 0;

  priority_dec_pulse_v #(.CODE_W(2), .HOLD_CYCLES(4), .GAP_CYCLES(1)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_code(a_code), .i_valid(a_valid),
    .o_ready(a_ready), .i_abort(a_abort), .o_onehot(a_onehot),
    .o_active(a_active), .o_code_q(a_codeq), .o_done(a_done)
  );

  priority_dec_pulse_v #(.CODE_W(2), .HOLD_CYCLES(4), .GAP_CYCLES(0)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_code(b_code), .i_valid(b_valid),
    .o_ready(b_ready), .i_abort(b_abort), .o_onehot(b_onehot),
    .o_active(b_active), .o_code_q(b_codeq), .o_done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sel;     // 0 = instance A, 1 = instance B
    logic       valid;
    logic [1:0] code;
    logic       abort;
    logic       ready;
    logic [3:0] onehot;
    logic       active;
    logic       done;
    logic [1:0] codeq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic v, input logic [1:0] c,
                              input logic ab, input logic r, input logic [3:0] oh,
                              input logic act, input logic d, input logic [1:0] q);
    vec_t t;
    t.sel = s; t.valid = v; t.code = c; t.abort = ab;
    t.ready = r; t.onehot = oh; t.active = act; t.done = d; t.codeq = q;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int idx, input logic r, input logic [3:0] oh,
                       input logic act, input logic d, input logic [1:0] q);
    chk({tag, " ready"},  idx, int'(a_ready),  int'(r));
    chk({tag, " onehot"}, idx, int'(a_onehot), int'(oh));
    chk({tag, " active"}, idx, int'(a_active), int'(act));
    chk({tag, " done"},   idx, int'(a_done),   int'(d));
    chk({tag, " code_q"}, idx, int'(a_codeq),  int'(q));
  endtask

  task automatic chk_b(input string tag, input int idx, input logic r, input logic [3:0] oh,
                       input logic act, input logic d, input logic [1:0] q);
    chk({tag, " ready"},  idx, int'(b_ready),  int'(r));
    chk({tag, " onehot"}, idx, int'(b_onehot), int'(oh));
    chk({tag, " active"}, idx, int'(b_active), int'(act));
    chk({tag, " done"},   idx, int'(b_done),   int'(d));
    chk({tag, " code_q"}, idx, int'(b_codeq),  int'(q));
  endtask

  initial begin
    // Single code 2 on A: 4 HOLD cycles, done on the 4th, one GAP cycle, IDLE.
    vecs.push_back(mk(0, 1, 2'd2, 0, 1, 4'b0000, 0, 0, 2'd0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 4'b0100, 1, 0, 2'd2));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 4'b0100, 1, 0, 2'd2));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 4'b0100, 1, 0, 2'd2));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 4'b0100, 1, 1, 2'd2));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 4'b0000, 0, 0, 2'd2));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 4'b0000, 0, 0, 2'd2));
    // Back-to-back 1 then 3 on A with valid held while not ready.
    vecs.push_back(mk(0, 1, 2'd1, 0, 1, 4'b0000, 0, 0, 2'd2));
    vecs.push_back(mk(0, 1, 2'd3, 0, 1, 4'b0010, 1, 0, 2'd1));
    vecs.push_back(mk(0, 1, 2'd3, 0, 0, 4'b0010, 1, 0, 2'd1));
    vecs.push_back(mk(0, 1, 2'd3, 0, 0, 4'b0010, 1, 0, 2'd1));
    vecs.push_back(mk(0, 1, 2'd3, 0, 0, 4'b0010, 1, 1, 2'd1));
    vecs.push_back(mk(0, 1, 2'd3, 0, 0, 4'b0000, 0, 0, 2'd1));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 4'b1000, 1, 0, 2'd3));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 4'b1000, 1, 0, 2'd3));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 4'b1000, 1, 0, 2'd3));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 4'b1000, 1, 1, 2'd3));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 4'b0000, 0, 0, 2'd3));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 4'b0000, 0, 0, 2'd3));
    // Abort on the last HOLD cycle of code 1 with code 3 pending.
    vecs.push_back(mk(0, 1, 2'd1, 0, 1, 4'b0000, 0, 0, 2'd3));
    vecs.push_back(mk(0, 1, 2'd3, 0, 1, 4'b0010, 1, 0, 2'd1));
    vecs.push_back(mk(0, 0, 2'd0, 0, 0, 4'b0010, 1, 0, 2'd1));
    vecs.push_back(mk(0, 0, 2'd0, 0, 0, 4'b0010, 1, 0, 2'd1));
    vecs.push_back(mk(0, 0, 2'd0, 1, 0, 4'b0010, 1, 0, 2'd1));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 4'b0000, 0, 0, 2'd1));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 4'b0000, 0, 0, 2'd1));
    // GAP=0 on B: codes 0,0,2 streamed, no zero cycle between selects.
    vecs.push_back(mk(1, 1, 2'd0, 0, 1, 4'b0000, 0, 0, 2'd0));
    vecs.push_back(mk(1, 1, 2'd0, 0, 1, 4'b0001, 1, 0, 2'd0));
    vecs.push_back(mk(1, 1, 2'd2, 0, 0, 4'b0001, 1, 0, 2'd0));
    vecs.push_back(mk(1, 1, 2'd2, 0, 0, 4'b0001, 1, 0, 2'd0));
    vecs.push_back(mk(1, 1, 2'd2, 0, 0, 4'b0001, 1, 1, 2'd0));
    vecs.push_back(mk(1, 1, 2'd2, 0, 1, 4'b0001, 1, 0, 2'd0));
    vecs.push_back(mk(1, 0, 2'd0, 0, 0, 4'b0001, 1, 0, 2'd0));
    vecs.push_back(mk(1, 0, 2'd0, 0, 0, 4'b0001, 1, 0, 2'd0));
    vecs.push_back(mk(1, 0, 2'd0, 0, 0, 4'b0001, 1, 1, 2'd0));
    vecs.push_back(mk(1, 0, 2'd0, 0, 1, 4'b0100, 1, 0, 2'd2));
    vecs.push_back(mk(1, 0, 2'd0, 0, 1, 4'b0100, 1, 0, 2'd2));
    vecs.push_back(mk(1, 0, 2'd0, 0, 1, 4'b0100, 1, 0, 2'd2));
    vecs.push_back(mk(1, 0, 2'd0, 0, 1, 4'b0100, 1, 1, 2'd2));
    vecs.push_back(mk(1, 0, 2'd0, 0, 1, 4'b0000, 0, 0, 2'd2));

    rst_n = 1'b0;
    a_valid = 1'b0; a_code = '0; a_abort = 1'b0;
    b_valid = 1'b0; b_code = '0; b_abort = 1'b0;

    // Reset and idle.
    repeat (3) @(negedge clk);
    #1;
    chk_a("rst A", 0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    chk_b("rst B", 0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_a("idle A", 0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
    chk_b("idle B", 0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].sel == 1'b0) begin
        a_valid = vecs[i].valid; a_code = vecs[i].code; a_abort = vecs[i].abort;
        b_valid = 1'b0; b_code = '0; b_abort = 1'b0;
      end else begin
        b_valid = vecs[i].valid; b_code = vecs[i].code; b_abort = vecs[i].abort;
        a_valid = 1'b0; a_code = '0; a_abort = 1'b0;
      end
      #1;
      if (vecs[i].sel == 1'b0)
        chk_a("vecA", i, vecs[i].ready, vecs[i].onehot, vecs[i].active, vecs[i].done, vecs[i].codeq);
      else
        chk_b("vecB", i, vecs[i].ready, vecs[i].onehot, vecs[i].active, vecs[i].done, vecs[i].codeq);
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // Asynchronous reset mid-HOLD on A, then recovery.
    a_valid = 1'b1; a_code = 2'd3;
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    chk_a("pre-rst", 0, 1'b1, 4'b1000, 1'b1, 1'b0, 2'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk_a("async rst", 0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1'b1; a_code = 2'd0;
    #1;
    chk_a("recover", 0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    chk_a("recover", 1, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0);
    repeat (6) @(negedge clk);
    #1;
    chk_a("recover", 2, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
